// File: rtl/cozy_memory_pkg.sv
// cozy_memory_pkg: shared widths, byte-lane helpers and the init FSM
// encoding for the two-port byte-addressed memory (cozy_memory_arb).
//   WORD_W / BYTE_W : storage word and byte widths
//   state_e         : INIT (zero sweep running) / RUN
//   lane_is_hi()    : decode addr[0] into a byte-lane select
//   steer_read()    : assemble read data for the selected lane
package cozy_memory_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // addr[0]=1 addresses the high byte of the word.
    function automatic logic lane_is_hi(input logic addr_lsb);
        return addr_lsb;
    endfunction

    // Word access returns {hi, lo}; odd-byte access returns the high byte
    // zero-extended.
    function automatic logic [WORD_W-1:0] steer_read(input logic [BYTE_W-1:0] hi,
                                                     input logic [BYTE_W-1:0] lo,
                                                     input logic              hi_lane);
        return hi_lane ? {{BYTE_W{1'b0}}, hi} : {hi, lo};
    endfunction

endpackage

// File: rtl/cozy_memory_arbiter.sv
// cozy_memory_arbiter: two-requester grant logic with a last-grant register.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : grants allowed this cycle (low during reset / init sweep)
//   a_req, b_req : requests
//   a_gnt, b_gnt : combinational grants, at most one high per cycle
// ROUND_ROBIN=0 gives A fixed priority; ROUND_ROBIN=1 hands a contended
// cycle to the port that was not granted last.
module cozy_memory_arbiter
    import cozy_memory_pkg::*;
#(
    parameter int ROUND_ROBIN = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt,
    output logic b_gnt
);

    // 1 = B held the most recent grant. Resets to B so the first contention
    // goes to A.
    logic last_b_q;
    logic last_b_d;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (en) begin
            if (a_req && b_req) begin
                if (ROUND_ROBIN == 0 || last_b_q) begin
                    a_gnt = 1'b1;
                end else begin
                    b_gnt = 1'b1;
                end
            end else begin
                a_gnt = a_req;
                b_gnt = b_req;
            end
        end

        // Tracks every grant, contended or not.
        last_b_d = last_b_q;
        if (a_gnt) begin
            last_b_d = 1'b0;
        end else if (b_gnt) begin
            last_b_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end

endmodule

// File: rtl/cozy_memory_arb.sv
// cozy_memory_arb: two-port byte-addressed 16-bit memory shared by a CPU
// port (A) and a video fetch port (B) through a request/ack arbiter.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   a_req/a_addr/a_din/a_bwe   : port A request, held until a_ack
//   a_ack                      : port A grant, combinational
//   a_dout/a_rvalid            : port A registered read data + 1-cycle strobe
//   b_*                        : identical port B
//   busy                       : array unavailable (zero-init sweep)
// addr[0] selects the byte lane, addr[ADDR_W-1:1] the word. bwe==0 is a read.
// Optional macro COZY_MEMORY_ZERO_INIT_EN: after reset, sweep zeros into
// every word (one per cycle) while holding busy high.
module cozy_memory_arb
    import cozy_memory_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int ADDR_W      = 13,
    parameter int ROUND_ROBIN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [15:0]       a_din,
    input  logic [1:0]        a_bwe,
    output logic              a_ack,
    output logic [15:0]       a_dout,
    output logic              a_rvalid,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [15:0]       b_din,
    input  logic [1:0]        b_bwe,
    output logic              b_ack,
    output logic [15:0]       b_dout,
    output logic              b_rvalid,
    output logic              busy
);

    localparam int WA_W  = ADDR_W - 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BYTE_W-1:0] mem_lo [DEPTH];
    logic [BYTE_W-1:0] mem_hi [DEPTH];

    logic busy_int;
    logic arb_en;

    // ---------------- zero-init sweep ----------------
`ifdef COZY_MEMORY_ZERO_INIT_EN
    state_e           state_q;
    logic [IDX_W-1:0] sweep_q;
    logic             busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            sweep_q <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                INIT: begin
                    if (sweep_q == IDX_W'(DEPTH - 1)) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= RUN;
                end
            endcase
        end
    end

    assign busy_int = busy_q;
`else
    assign busy_int = 1'b0;
`endif

    assign busy = busy_int;

    // No grants while reset is asserted or the sweep owns the array.
    assign arb_en = rst_n & ~busy_int;

    cozy_memory_arbiter #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_arbiter (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en),
        .a_req (a_req),
        .b_req (b_req),
        .a_gnt (a_ack),
        .b_gnt (b_ack)
    );

    // ---------------- address decode ----------------
    logic [WA_W-1:0] a_word;
    logic [WA_W-1:0] b_word;
    logic            a_ok;
    logic            b_ok;

    assign a_word = a_addr[ADDR_W-1:1];
    assign b_word = b_addr[ADDR_W-1:1];
    assign a_ok   = (int'(a_word) < DEPTH);
    assign b_ok   = (int'(b_word) < DEPTH);

    // ---------------- write steering ----------------
    logic [15:0]       g_din;
    logic [1:0]        g_bwe;
    logic              g_hi;
    logic              g_ok;
    logic [IDX_W-1:0]  wr_idx;
    logic              wr_lo_en;
    logic              wr_hi_en;
    logic [BYTE_W-1:0] wr_lo_dat;
    logic [BYTE_W-1:0] wr_hi_dat;

    always_comb begin
        g_din  = b_ack ? b_din : a_din;
        g_bwe  = b_ack ? b_bwe : a_bwe;
        g_hi   = b_ack ? lane_is_hi(b_addr[0]) : lane_is_hi(a_addr[0]);
        g_ok   = b_ack ? b_ok : a_ok;
        wr_idx = b_ack ? b_word[IDX_W-1:0] : a_word[IDX_W-1:0];

        // An odd-byte write takes its data from din[7:0] under bwe[0] and
        // lands in the high byte; bwe[1] has no meaning there.
        wr_lo_en  = (a_ack | b_ack) & g_ok & ~g_hi & g_bwe[0];
        wr_hi_en  = (a_ack | b_ack) & g_ok & (g_hi ? g_bwe[0] : g_bwe[1]);
        wr_lo_dat = g_din[7:0];
        wr_hi_dat = g_hi ? g_din[7:0] : g_din[15:8];

`ifdef COZY_MEMORY_ZERO_INIT_EN
        // Acks are blocked while busy, so the sweep never collides with a port.
        if (busy_int) begin
            wr_idx    = sweep_q;
            wr_lo_en  = 1'b1;
            wr_hi_en  = 1'b1;
            wr_lo_dat = '0;
            wr_hi_dat = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_lo_en) begin
            mem_lo[wr_idx] <= wr_lo_dat;
        end
        if (wr_hi_en) begin
            mem_hi[wr_idx] <= wr_hi_dat;
        end
    end

    // ---------------- read pipeline ----------------
    // The acked read's address is captured at the ack edge and the array is
    // read one cycle later, so a write granted just before the read is seen.
    logic             a_rd_pend_q, a_rd_pend_d;
    logic             b_rd_pend_q, b_rd_pend_d;
    logic [IDX_W-1:0] a_rd_idx_q, a_rd_idx_d;
    logic [IDX_W-1:0] b_rd_idx_q, b_rd_idx_d;
    logic             a_rd_hi_q, a_rd_hi_d;
    logic             b_rd_hi_q, b_rd_hi_d;
    logic             a_rd_ok_q, a_rd_ok_d;
    logic             b_rd_ok_q, b_rd_ok_d;
    logic [15:0]      a_dout_q, a_dout_d;
    logic [15:0]      b_dout_q, b_dout_d;
    logic             a_rvalid_q, a_rvalid_d;
    logic             b_rvalid_q, b_rvalid_d;

    always_comb begin
        a_rd_pend_d = a_ack & (a_bwe == 2'b00);
        b_rd_pend_d = b_ack & (b_bwe == 2'b00);
        a_rd_idx_d  = a_word[IDX_W-1:0];
        b_rd_idx_d  = b_word[IDX_W-1:0];
        a_rd_hi_d   = lane_is_hi(a_addr[0]);
        b_rd_hi_d   = lane_is_hi(b_addr[0]);
        a_rd_ok_d   = a_ok;
        b_rd_ok_d   = b_ok;

        a_rvalid_d = a_rd_pend_q;
        b_rvalid_d = b_rd_pend_q;

        // dout holds between reads; out-of-range reads return zero.
        a_dout_d = a_dout_q;
        if (a_rd_pend_q) begin
            a_dout_d = a_rd_ok_q ? steer_read(mem_hi[a_rd_idx_q], mem_lo[a_rd_idx_q], a_rd_hi_q)
                                 : '0;
        end
        b_dout_d = b_dout_q;
        if (b_rd_pend_q) begin
            b_dout_d = b_rd_ok_q ? steer_read(mem_hi[b_rd_idx_q], mem_lo[b_rd_idx_q], b_rd_hi_q)
                                 : '0;
        end
    end

    // Reset cancels any read in flight and clears the read registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rd_pend_q <= 1'b0;
            b_rd_pend_q <= 1'b0;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
            a_dout_q    <= '0;
            b_dout_q    <= '0;
        end else begin
            a_rd_pend_q <= a_rd_pend_d;
            b_rd_pend_q <= b_rd_pend_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
            a_dout_q    <= a_dout_d;
            b_dout_q    <= b_dout_d;
        end
    end

    always_ff @(posedge clk) begin
        a_rd_idx_q <= a_rd_idx_d;
        b_rd_idx_q <= b_rd_idx_d;
        a_rd_hi_q  <= a_rd_hi_d;
        b_rd_hi_q  <= b_rd_hi_d;
        a_rd_ok_q  <= a_rd_ok_d;
        b_rd_ok_q  <= b_rd_ok_d;
    end

    assign a_dout   = a_dout_q;
    assign b_dout   = b_dout_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;

endmodule

// File: tb/tb_cozy_memory_arb.sv
// tb_cozy_memory_arb: directed bench for cozy_memory_arb with DEPTH=4.
// A round-robin instance carries all data checks through a read scoreboard;
// a fixed-priority instance shares the stimulus for the contention checks.
// Honours COZY_MEMORY_ZERO_INIT_EN when defined for the build.
module tb_cozy_memory_arb;

    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          a_req, b_req;
    logic [AW-1:0] a_addr, b_addr;
    logic [15:0]   a_din, b_din;
    logic [1:0]    a_bwe, b_bwe;

    logic          a_ack, b_ack, a_rvalid, b_rvalid, busy;
    logic [15:0]   a_dout, b_dout;
    logic          fp_a_ack, fp_b_ack, fp_a_rvalid, fp_b_rvalid, fp_busy;
    logic [15:0]   fp_a_dout, fp_b_dout;

    int checks = 0;
    int errors = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic        pend_a = 1'b0, pend_b = 1'b0;
    logic        exp_rv_a = 1'b0, exp_rv_b = 1'b0;

    always #5 clk = ~clk;

    cozy_memory_arb #(.DEPTH(4), .ADDR_W(AW), .ROUND_ROBIN(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_din(a_din), .a_bwe(a_bwe),
        .a_ack(a_ack), .a_dout(a_dout), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_addr(b_addr), .b_din(b_din), .b_bwe(b_bwe),
        .b_ack(b_ack), .b_dout(b_dout), .b_rvalid(b_rvalid),
        .busy(busy)
    );

    cozy_memory_arb #(.DEPTH(4), .ADDR_W(AW), .ROUND_ROBIN(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_din(a_din), .a_bwe(a_bwe),
        .a_ack(fp_a_ack), .a_dout(fp_a_dout), .a_rvalid(fp_a_rvalid),
        .b_req(b_req), .b_addr(b_addr), .b_din(b_din), .b_bwe(b_bwe),
        .b_ack(fp_b_ack), .b_dout(fp_b_dout), .b_rvalid(fp_b_rvalid),
        .busy(fp_busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Read scoreboard: an acked read must give rvalid exactly one cycle after
    // its ack edge, carrying the value queued when the read was accepted.
    always @(negedge clk) begin
        pend_a = rst_n && a_req && a_ack && (a_bwe == 2'b00);
        pend_b = rst_n && b_req && b_ack && (b_bwe == 2'b00);
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            exp_rv_a = 1'b0;
            exp_rv_b = 1'b0;
        end else begin
            chk("a_rvalid", {15'b0, a_rvalid}, {15'b0, exp_rv_a});
            if (a_rvalid === 1'b1 && qa.size() > 0) chk("a_dout", a_dout, qa.pop_front());
            chk("b_rvalid", {15'b0, b_rvalid}, {15'b0, exp_rv_b});
            if (b_rvalid === 1'b1 && b_rvalid === 1'b1 && qb.size() > 0) chk("b_dout", b_dout, qb.pop_front());
            exp_rv_a = pend_a;
            exp_rv_b = pend_b;
        end
    end

    // Starts at posedge+1; returns at posedge+1 after the ack edge with the
    // request still asserted so consecutive calls run at full rate.
    task automatic access(input bit pb, input logic [AW-1:0] addr, input logic [15:0] din,
                          input logic [1:0] bwe, input logic [15:0] exp, input bit push,
                          input int exp_wait);
        int waited = 0;
        bit got = 1'b0;
        if (pb) begin
            b_req = 1'b1; b_addr = addr; b_din = din; b_bwe = bwe;
        end else begin
            a_req = 1'b1; a_addr = addr; a_din = din; a_bwe = bwe;
        end
        while (!got && waited < 20) begin
            #1;
            got = pb ? b_ack : a_ack;
            @(posedge clk);
            if (!got) waited++;
            #1;
        end
        chk(pb ? "b_ack_wait" : "a_ack_wait", 16'(waited), 16'(exp_wait));
        if (got && push && bwe == 2'b00) begin
            if (pb) qb.push_back(exp);
            else    qa.push_back(exp);
        end
    endtask

    task automatic idle();
        a_req = 1'b0; b_req = 1'b0; a_bwe = 2'b00; b_bwe = 2'b00;
        @(posedge clk);
        #1;
    endtask

    // Entered just after rst_n rises (mid-cycle); busy must stay high for
    // exactly four cycles, then an optionally pending read is acked at once.
    task automatic sweep_watch(input bit with_req);
        if (with_req) begin
            a_req = 1'b1; a_addr = '0; a_bwe = 2'b00;
        end
        for (int k = 0; k <= 4; k++) begin
            #1;
            chk("busy_sweep", {15'b0, busy}, {15'b0, (k < 4)});
            if (with_req) begin
                chk("a_ack_after_busy", {15'b0, a_ack}, {15'b0, (k == 4)});
                if (k == 4) qa.push_back(16'h0000);
            end
            @(posedge clk);
        end
        #1;
        a_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b1; b_req = 1'b1;
        a_addr = '0; b_addr = '0; a_din = '0; b_din = '0;
        a_bwe = 2'b00; b_bwe = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        // ---- reset state, with both requests held high ----
        chk("rst_a_ack", {15'b0, a_ack}, 16'h0);
        chk("rst_b_ack", {15'b0, b_ack}, 16'h0);
        chk("rst_a_rvalid", {15'b0, a_rvalid}, 16'h0);
        chk("rst_b_rvalid", {15'b0, b_rvalid}, 16'h0);
        chk("rst_a_dout", a_dout, 16'h0000);
        chk("rst_b_dout", b_dout, 16'h0000);
`ifdef COZY_MEMORY_ZERO_INIT_EN
        chk("rst_busy", {15'b0, busy}, 16'h1);
`else
        chk("rst_busy", {15'b0, busy}, 16'h0);
`endif
        a_req = 1'b0; b_req = 1'b0;
        #2 rst_n = 1'b1;
`ifdef COZY_MEMORY_ZERO_INIT_EN
        sweep_watch(1'b0);
`else
        #1;
        chk("busy_run", {15'b0, busy}, 16'h0);
        @(posedge clk);
        #1;
`endif

        // ---- contention: out-of-range reads on both ports ----
        a_req = 1'b1; b_req = 1'b1; a_bwe = 2'b00; b_bwe = 2'b00;
        a_addr = 13'h8; b_addr = 13'h9;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_a_ack", {15'b0, a_ack}, {15'b0, (i % 2 == 0)});
            chk("rr_b_ack", {15'b0, b_ack}, {15'b0, (i % 2 == 1)});
            chk("fp_a_ack", {15'b0, fp_a_ack}, 16'h1);
            chk("fp_b_ack", {15'b0, fp_b_ack}, 16'h0);
            if (i % 2 == 0) qa.push_back(16'h0000);
            else            qb.push_back(16'h0000);
            @(posedge clk);
            #1;
        end
        idle();

        // ---- word writes on A (full rate), word reads on B ----
        access(0, 13'h0, 16'h1234, 2'b11, 16'h0, 0, 0);
        access(0, 13'h2, 16'h5678, 2'b11, 16'h0, 0, 0);
        access(0, 13'h4, 16'h9abc, 2'b11, 16'h0, 0, 0);
        access(0, 13'h6, 16'hcdef, 2'b11, 16'h0, 0, 0);
        idle();
        access(1, 13'h0, 16'h0, 2'b00, 16'h1234, 1, 0);
        access(1, 13'h2, 16'h0, 2'b00, 16'h5678, 1, 0);
        access(1, 13'h4, 16'h0, 2'b00, 16'h9abc, 1, 0);
        access(1, 13'h6, 16'h0, 2'b00, 16'hcdef, 1, 0);
        idle();

        // ---- byte lanes; read right after write of the same word ----
        access(0, 13'h0, 16'hABCD, 2'b01, 16'h0, 0, 0);
        access(0, 13'h1, 16'hBCDE, 2'b01, 16'h0, 0, 0);
        access(0, 13'h1, 16'h0, 2'b00, 16'h00DE, 1, 0);
        access(0, 13'h3, 16'h77AA, 2'b11, 16'h0, 0, 0);
        access(0, 13'h3, 16'h0, 2'b00, 16'h00AA, 1, 0);
        access(0, 13'h2, 16'h0, 2'b00, 16'hAA78, 1, 0);
        idle();
        access(1, 13'h0, 16'h0, 2'b00, 16'hDECD, 1, 0);
        idle();

        // ---- out of range: word index 4 ----
        access(0, 13'h8, 16'hFFFF, 2'b11, 16'h0, 0, 0);
        access(0, 13'h8, 16'h0, 2'b00, 16'h0000, 1, 0);
        access(0, 13'h9, 16'h0, 2'b00, 16'h0000, 1, 0);
        idle();
        access(1, 13'h0, 16'h0, 2'b00, 16'hDECD, 1, 0);
        access(1, 13'h2, 16'h0, 2'b00, 16'hAA78, 1, 0);
        access(1, 13'h4, 16'h0, 2'b00, 16'h9abc, 1, 0);
        access(1, 13'h6, 16'h0, 2'b00, 16'hcdef, 1, 0);
        idle();

        // ---- reset the cycle after a read ack ----
        access(1, 13'h0, 16'h0, 2'b00, 16'h0, 0, 0);
        b_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_b_rvalid", {15'b0, b_rvalid}, 16'h0);
        chk("rstmid_b_dout", b_dout, 16'h0000);
        @(posedge clk);
        #1;
        chk("rstmid_b_rvalid2", {15'b0, b_rvalid}, 16'h0);
        chk("rstmid_b_dout2", b_dout, 16'h0000);
        #2 rst_n = 1'b1;
`ifdef COZY_MEMORY_ZERO_INIT_EN
        // Pulse reset with the sweep at word 2; it must start over.
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("restart_busy", {15'b0, busy}, 16'h1);
        #1 rst_n = 1'b1;
        sweep_watch(1'b1);
        access(1, 13'h7, 16'h0, 2'b00, 16'h0000, 1, 0);
        idle();
`else
        @(posedge clk);
        #1;
        // Contents survive reset.
        access(0, 13'h0, 16'h0, 2'b00, 16'hDECD, 1, 0);
        idle();
`endif

        repeat (3) @(posedge clk);
        #2;
        chk("qa_drained", 16'(qa.size()), 16'h0);
        chk("qb_drained", 16'(qb.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Unused outputs of the priority instance still get a sanity look.
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    logic unused_fp;
    assign unused_fp = ^{fp_a_dout, fp_b_dout, fp_a_rvalid, fp_b_rvalid, fp_busy};

endmodule
